// File: rtl/int2float_arb.sv
// -----------------------------------------------------------------------------
// int2float_arb
//
// Round-robin front end for one shared combinational int->float converter.
// NREQ requesters offer integer operands through valid/ready handshakes. The
// arbiter grants one of them per cycle and registers the operand onto cv_in.
// The external converter answers on cv_out in the same cycle. One cycle after
// the grant, {cv_out, tag} goes into a 2-entry first-word-fall-through FIFO
// that feeds the valid/ready output port.
//
// Grants are credit-limited. Operands in flight plus buffered results never
// exceed the two FIFO slots, so the FIFO cannot overflow. Because of this,
// req_ready does not have to look at out_ready. With out_ready held high the
// block accepts one operand per cycle and returns one result per cycle.
//
// Ports
//   clk        sole clock; all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   req_valid  [NREQ]      per-requester operand valid
//   req_data   [NREQ*IW]   operands; requester i occupies [i*IW +: IW]
//   req_ready  [NREQ]      per-requester accept (one-hot or zero)
//   cv_in      [IW]        registered operand sent to the converter
//   cv_out     [OW]        converter result for cv_in, same cycle
//   out_valid              result available at the FIFO head
//   out_ready              downstream accept
//   out_data   [OW]        converted value at the FIFO head
//   out_tag    [TW]        index of the requester that produced out_data
//   busy                   an operand is in flight or a result is buffered
// -----------------------------------------------------------------------------
module int2float_arb #(
   parameter int NREQ = 4,
   parameter int IW   = 11,
   parameter int OW   = 7,
   parameter int TW   = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*IW-1:0] req_data,
   output logic [NREQ-1:0]    req_ready,
   output logic [IW-1:0]      cv_in,
   input  logic [OW-1:0]      cv_out,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OW-1:0]      out_data,
   output logic [TW-1:0]      out_tag,
   output logic               busy
);

   localparam int EW = OW + TW;   // FIFO entry: {result, tag}

   // Stage 1: arbiter pointer and registered operand
   logic [TW-1:0] rr_q, rr_d;
   logic          inflight_q, inflight_d;
   logic [TW-1:0] tag_q, tag_d;
   logic [IW-1:0] cv_in_q, cv_in_d;

   // Stage 2: two-entry output FIFO
   logic [EW-1:0] fifo_mem_q [2];
   logic          wr_ptr_q, wr_ptr_d;
   logic          rd_ptr_q, rd_ptr_d;
   logic [1:0]    count_q, count_d;

   // Handshake and arbitration helpers
   logic          push;
   logic          pop;
   logic [2:0]    occupancy;
   logic          credit_ok;
   logic          grant_vld;
   logic [TW-1:0] grant_idx;
   logic [IW-1:0] sel_data;
   logic [TW:0]   scan_idx;
   logic [EW-1:0] head;

   // -------------------------------------------------------------------------
   // Output side. While reset is held low, all outputs read as idle. Otherwise
   // pre-reset garbage in count_q could appear as a valid result.
   // -------------------------------------------------------------------------
   always_comb begin
      head      = fifo_mem_q[rd_ptr_q];
      out_valid = rst_n & (count_q != 2'd0);
      out_data  = head[EW-1:TW];
      out_tag   = head[TW-1:0];
      busy      = rst_n & (inflight_q | (count_q != 2'd0));
      cv_in     = cv_in_q;
   end

   always_comb begin
      pop  = out_valid & out_ready;
      push = inflight_q;
      // A pop implies count_q >= 1, so this difference cannot wrap.
      occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
      credit_ok = (occupancy < 3'd2);
   end

   // -------------------------------------------------------------------------
   // Round-robin search. Start at rr_q, wrap modulo NREQ, and take the first
   // valid requester. A requester that drops valid before it is reached is
   // simply skipped, and the pointer only moves on an actual grant.
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path leaves
      // it unassigned and no latch is inferred.
      grant_vld = 1'b0;
      grant_idx = '0;
      sel_data  = '0;
      scan_idx  = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan_idx = {1'b0, rr_q} + (TW+1)'(k);
         if (scan_idx >= (TW+1)'(NREQ)) begin
            scan_idx = scan_idx - (TW+1)'(NREQ);
         end
         if (!grant_vld && req_valid[scan_idx[TW-1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = scan_idx[TW-1:0];
            sel_data  = req_data[scan_idx[TW-1:0]*IW +: IW];
         end
      end
      grant_vld = grant_vld & credit_ok & rst_n;
   end

   always_comb begin
      req_ready = '0;
      if (grant_vld) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      rr_d       = rr_q;
      inflight_d = 1'b0;
      tag_d      = tag_q;
      cv_in_d    = cv_in_q;
      if (grant_vld) begin
         rr_d       = (grant_idx == TW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
         inflight_d = 1'b1;
         tag_d      = grant_idx;
         cv_in_d    = sel_data;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q ^ push;
      rd_ptr_d = rd_ptr_q ^ pop;
      // On push and pop in the same cycle, the pop frees the slot the push
      // fills, so count is unchanged, including when count is 2.
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments, so every flop
   // samples its pre-edge inputs no matter how the blocks are ordered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_q       <= '0;
         inflight_q <= 1'b0;
         tag_q      <= '0;
         cv_in_q    <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
      end else begin
         rr_q       <= rr_d;
         inflight_q <= inflight_d;
         tag_q      <= tag_d;
         cv_in_q    <= cv_in_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // NOTE: FIFO storage is not reset. count_q gates every read, so stale
   // entries are never visible, and leaving the memory unreset keeps it as
   // plain storage.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= {cv_out, tag_q};
      end
   end

   // -------------------------------------------------------------------------
   // The credit rule makes these cases unreachable.
   // -------------------------------------------------------------------------
   a_fifo_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !pop && (count_q == 2'd2)));

   a_fifo_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(pop && (count_q == 2'd0)));

   a_fifo_count_range : assert property (@(posedge clk) disable iff (!rst_n)
      count_q <= 2'd2);

endmodule

// File: tb/tb_int2float_arb.sv
// -----------------------------------------------------------------------------
// tb_int2float_arb
//
// Scoreboard bench for int2float_arb.
//
// The bench plays the role of the shared converter: cv_out = i2f(cv_in).
// i2f is an unsigned int->float mapping:
//   - zero maps to zero;
//   - otherwise exponent = msb_position + 1 (4 bits);
//   - mantissa = the 3 bits just below the leading one (truncated).
//
// A predictor process keeps its own arbiter and credit model. It checks
// req_ready, out_valid and busy each cycle. On every predicted accept it
// pushes the expected {result, tag}. A monitor process compares the FIFO head
// against the scoreboard front whenever out_valid is high, and pops it on
// out_ready. A directed driver adds hand-computed checks on top of the model.
// -----------------------------------------------------------------------------
module tb_int2float_arb;

   localparam int NREQ = 4;
   localparam int IW   = 11;
   localparam int OW   = 7;
   localparam int TW   = 2;

   typedef struct {
      logic [OW-1:0] data;
      logic [TW-1:0] tag;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*IW-1:0] req_data;
   logic [NREQ-1:0]    req_ready;
   logic [IW-1:0]      cv_in;
   logic [OW-1:0]      cv_out;
   logic               out_valid;
   logic               out_ready;
   logic [OW-1:0]      out_data;
   logic [TW-1:0]      out_tag;
   logic               busy;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   int2float_arb #(.NREQ(NREQ), .IW(IW), .OW(OW), .TW(TW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .cv_in     (cv_in),
      .cv_out    (cv_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag),
      .busy      (busy)
   );

   function automatic logic [OW-1:0] i2f(input logic [IW-1:0] x);
      logic [IW-1:0] s;
      int            p;
      p = -1;
      for (int i = 0; i < IW; i++) begin
         if (x[i] === 1'b1) p = i;
      end
      if (p < 0) return '0;
      s = x << (IW - 1 - p);
      return {4'(p + 1), s[IW-2 -: 3]};
   endfunction

   assign cv_out = i2f(cv_in);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of stimulus at the falling edge, then let the
   // combinational outputs settle.
   task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*IW-1:0] d,
                       input logic ordy, input logic rn);
      @(negedge clk);
      req_valid = v;
      req_data  = d;
      out_ready = ordy;
      rst_n     = rn;
      #2;
   endtask

   // ---------------------------------------------------------------------------
   // Predictor: reference arbiter and credit model; pushes expected results.
   // ---------------------------------------------------------------------------
   initial begin : predictor
      int            m_rr;
      int            m_count;
      int            m_inflight;
      int            m_pop;
      int            g;
      int            idx;
      logic [NREQ-1:0] exp_ready;
      m_rr = 0; m_count = 0; m_inflight = 0;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n !== 1'b1) begin
            check("reset_req_ready", 32'(req_ready), 32'h0);
            check("reset_out_valid", 32'(out_valid), 32'h0);
            check("reset_busy",      32'(busy),      32'h0);
            m_rr = 0; m_count = 0; m_inflight = 0;
            sb_q.delete();
         end else begin
            m_pop = (m_count != 0 && out_ready === 1'b1) ? 1 : 0;
            g = -1;
            if (m_count + m_inflight - m_pop < 2) begin
               for (int k = 0; k < NREQ; k++) begin
                  idx = (m_rr + k) % NREQ;
                  if (g < 0 && req_valid[idx] === 1'b1) g = idx;
               end
            end
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            check("model_req_ready", 32'(req_ready), 32'(exp_ready));
            check("model_out_valid", 32'(out_valid), (m_count != 0) ? 32'h1 : 32'h0);
            check("model_busy", 32'(busy), (m_count != 0 || m_inflight != 0) ? 32'h1 : 32'h0);
            if (g >= 0) begin
               sb_q.push_back('{data: i2f(req_data[g*IW +: IW]), tag: TW'(g)});
               m_rr = (g + 1) % NREQ;
            end
            m_count    = m_count + m_inflight - m_pop;
            m_inflight = (g >= 0) ? 1 : 0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Monitor: compares the FIFO head with the scoreboard front.
   // ---------------------------------------------------------------------------
   initial begin : monitor
      forever begin
         @(negedge clk);
         #2;
         if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL stale_result: out_valid with tag %0h data %0h, expected no result (t=%0t)",
                        out_tag, out_data, $time);
            end else begin
               check("sb_out_data", 32'(out_data), 32'(sb_q[0].data));
               check("sb_out_tag",  32'(out_tag),  32'(sb_q[0].tag));
               if (out_ready === 1'b1) void'(sb_q.pop_front());
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Directed stimulus with hand-computed expectations
   // Requester data: r0=0x123 -> 0x49, r1=0x040 -> 0x38, r2=0x005 -> 0x1A,
   //                 r3=0x7FF -> 0x5F
   // ---------------------------------------------------------------------------
   localparam logic [NREQ*IW-1:0] D_ALL = {11'h7FF, 11'h005, 11'h040, 11'h123};
   localparam logic [NREQ*IW-1:0] D_ONE = {11'h000, 11'h040, 11'h000, 11'h000};

   initial begin : driver
      logic [NREQ-1:0]    bp_exp [4];
      logic [63:0]        r;
      rst_n = 1'b0; req_valid = '0; req_data = '0; out_ready = 1'b0;
      bp_exp = '{4'b0001, 4'b0010, 4'b0000, 4'b0000};

      // Reset holds everything idle even with all requests pending.
      step(4'h0, '0, 1'b0, 1'b0);
      step(4'h0, '0, 1'b0, 1'b0);
      step(4'hF, D_ALL, 1'b1, 1'b0);
      check("rst_req_ready", 32'(req_ready), 32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);

      // Single request from requester 2; result two cycles later.
      step(4'b0100, D_ONE, 1'b1, 1'b1);
      check("single_grant", 32'(req_ready), 32'h4);
      step(4'b0000, D_ONE, 1'b1, 1'b1);
      check("single_busy_inflight", 32'(busy), 32'h1);
      check("single_not_yet_valid", 32'(out_valid), 32'h0);
      step(4'b0000, D_ONE, 1'b1, 1'b1);
      check("single_valid", 32'(out_valid), 32'h1);
      check("single_tag",   32'(out_tag),   32'h2);
      check("single_data",  32'(out_data),  32'h38);
      step(4'b0000, D_ONE, 1'b1, 1'b1);
      check("single_drained", 32'(out_valid), 32'h0);

      // Full round-robin stream from reset, out_ready held high.
      step(4'h0, D_ALL, 1'b1, 1'b0);
      for (int k = 0; k < 12; k++) begin
         step(4'hF, D_ALL, 1'b1, 1'b1);
         check("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
         if (k >= 2) begin
            check("rr_stream_valid", 32'(out_valid), 32'h1);
            check("rr_stream_tag",   32'(out_tag),   32'((k - 2) % 4));
         end
      end

      // Backpressure: two accepts fill the credit, then the head holds stable.
      step(4'h0, D_ALL, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) begin
         step(4'hF, D_ALL, 1'b0, 1'b1);
         check("bp_grant", 32'(req_ready), 32'(bp_exp[k]));
         if (k >= 2) check("bp_head_stable", 32'(out_data), 32'h49);
      end
      check("bp_busy", 32'(busy), 32'h1);
      // Release for one cycle: the pop and a new accept happen together.
      step(4'hF, D_ALL, 1'b1, 1'b1);
      check("bp_release_grant", 32'(req_ready), 32'h4);
      check("bp_release_tag",   32'(out_tag),   32'h0);

      // Reset mid-stream: an operand is in flight and one result is buffered.
      step(4'h0, D_ALL, 1'b0, 1'b0);
      step(4'h0, D_ALL, 1'b1, 1'b1);
      check("midrst_out_valid", 32'(out_valid), 32'h0);
      check("midrst_busy",      32'(busy),      32'h0);
      for (int k = 0; k < 3; k++) step(4'h0, D_ALL, 1'b1, 1'b1);
      step(4'hF, D_ALL, 1'b1, 1'b1);
      check("midrst_rr_zero", 32'(req_ready), 32'h1);

      // Pointer skip: rr=1 with requesters 0 and 3 valid.
      step(4'h0, D_ALL, 1'b1, 1'b0);
      step(4'b0001, D_ALL, 1'b1, 1'b1);
      check("skip_first", 32'(req_ready), 32'h1);
      step(4'b1001, D_ALL, 1'b1, 1'b1);
      check("skip_to_3", 32'(req_ready), 32'h8);
      step(4'b1001, D_ALL, 1'b1, 1'b1);
      check("skip_wrap_0", 32'(req_ready), 32'h1);
      // Requester 1 is granted; requester 2 drops out and loses its turn.
      step(4'b0110, D_ALL, 1'b1, 1'b1);
      check("drop_grant_1", 32'(req_ready), 32'h2);
      step(4'b1000, D_ALL, 1'b1, 1'b1);
      check("drop_grant_3", 32'(req_ready), 32'h8);

      // Mixed traffic checked by the model and the scoreboard.
      for (int k = 0; k < 3000; k++) begin
         r = {$urandom(), $urandom()};
         step(4'($urandom_range(0, 15)), r[NREQ*IW-1:0], ($urandom_range(0, 3) != 0), 1'b1);
      end

      // Drain and confirm that every expected result came out.
      for (int k = 0; k < 8; k++) step(4'h0, '0, 1'b1, 1'b1);
      check("drain_empty", 32'(sb_q.size()), 32'h0);
      check("drain_idle",  32'(busy),        32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
